nfc_cmd_addr_sequencer: RTL and testbench
=========================================

Name: nfc_cmd_addr_sequencer

Overview:
- Sequences one NAND command/address transaction: a command byte, then 0–5 address bytes, on a selected way.
- Drives the half-resolution control and DQ bundle that feeds the NAND physical output stage: CE, WE, RE, ALE, CLE, DQ, the output enables, and DQS.
- Uses asynchronous (SDR) NAND timing, with pulse widths counted in iSystemClock cycles.
- Sits between the way/command scheduler and the physical output stage.

Parameters:
- NumberOfWays, 4, number of CE lines; must be a power of two, ≥2.
- SetupCycles, 1, CE/CLE/ALE/DQ setup before each phase's first WE fall; ≥1.
- WeLowCycles, 2, WE low width per byte; ≥1.
- WeHighCycles, 2, WE high width per byte; ≥1.
- HoldCycles, 1, CE/latch hold after the last WE rise; ≥1.

Ports:
- iSystemClock  in  1  clock.
- iModuleReset  in  1  asynchronous active-high reset.
- iStart  in  1  transaction request; accepted when iStart & oReady.
- iTargetWay  in  log2(NumberOfWays)  way to select.
- iCommand  in  8  command byte.
- iAddrCount  in  3  number of address bytes; 6 and 7 are treated as 5.
- iAddress  in  40  address bytes; byte 0 = [7:0] is sent first.
- oReady  out  1  idle, able to accept.
- oDone  out  1  one-cycle pulse at transaction end.
- oDQSOutEnable  out  1  always 0.
- oDQOutEnable  out  1  DQ drive request.
- oPO_DQStrobe  out  8  always 0.
- oPO_DQ  out  32  [7:0] and [23:16] carry the current byte; other bits 0.
- oPO_ChipEnable  out  2*NumberOfWays  active-low; bit w and bit w+NumberOfWays both reflect way w.
- oPO_ReadEnable  out  4  always 4'b1111.
- oPO_WriteEnable  out  4  all four bits equal the WE level.
- oPO_AddressLatchEnable  out  4  all four bits equal ALE.
- oPO_CommandLatchEnable  out  4  all four bits equal CLE.

Behaviour:
- Clocking and reset
  - All outputs are registered.
  - Reset values, which are also the idle values: oReady=1, oDone=0, CE all 1, WE 4'hF, RE 4'hF, ALE 0, CLE 0, DQ 0, oDQOutEnable 0.
  - Reset mid-transaction returns immediately to these values; no partial byte is completed.
- Acceptance
  - On the accepting edge, the sequencer latches all inputs and drops oReady.
  - While busy, iStart is ignored and the latched inputs are held regardless of input changes.
- State machine: IDLE → CMD_SETUP → CMD_WE_LO → CMD_WE_HI → [ADDR_SETUP → (ADDR_WE_LO → ADDR_WE_HI) × N] → HOLD → DONE → IDLE.
  - CMD_SETUP (SetupCycles): CE of the target way = 0, CLE=1, DQ=command, oDQOutEnable=1, WE high.
  - CMD_WE_LO / CMD_WE_HI: WE low for WeLowCycles, then high for WeHighCycles. DQ and CLE are held through both.
  - ADDR_SETUP (SetupCycles): CLE=0, ALE=1, DQ=address byte 0, WE high.
  - Each ADDR_WE_LO loads the next address byte on its first cycle. The byte stays stable through the following ADDR_WE_HI.
  - N=0 skips ADDR_SETUP and the address loop, going CMD_WE_HI → HOLD.
  - HOLD (HoldCycles): WE high, latch signals unchanged, CE still asserted.
  - DONE (1 cycle): CE deasserted, CLE=ALE=0, oDQOutEnable=0, DQ=0, oDone=1, oReady=1. A new iStart is accepted in this cycle.
- Counters and timing
  - One down-counter, wide enough for the maximum parameter value, is reloaded on each state entry.
  - An address byte index 0–4 tracks the loop; the loop exits when the index reaches N−1 after ADDR_WE_HI.
  - Busy time from the accepting edge to oDone = SetupCycles + WeLowCycles + WeHighCycles + (N>0 ? SetupCycles + N×(WeLowCycles+WeHighCycles) : 0) + HoldCycles.
- Boundary conditions
  - iStart asserted in the same cycle as DONE starts the next transaction with no IDLE gap.
  - Only one CE is ever low at a time.

Optional Feature:
- NFC_CMD2_EN defined:
  - Adds ports iCmd2Valid (1 bit) and iCommand2 (8 bits), latched at acceptance.
  - When iCmd2Valid=1, the sequence after the address phase is CMD2_SETUP → CMD2_WE_LO → CMD2_WE_HI, then HOLD. These states have the same timing as the first command phase: ALE=0, CLE=1, DQ=iCommand2.
  - Busy time increases by SetupCycles+WeLowCycles+WeHighCycles.
- NFC_CMD2_EN undefined: the ports are absent and behaviour is as above.

Decomposition:
- Shared package nfc_pkg:
  - state encoding typedef;
  - max address byte count 5;
  - idle-value constants for the WE/RE/CE bundles.
- One sub-module, nfc_phase_timer: a loadable down-counter with a terminal-count flag, reused for every timed state.

Test Plan:
- Defaults, way 2, command 8'h00, N=5, address 40'h0504030201:
  - CE bits 2 and 6 low for 27 cycles;
  - five ALE bytes in order 01, 02, 03, 04, 05;
  - each WE low for exactly 2 cycles;
  - oDone pulses on cycle 27.
- N=0, command 8'hFF: CLE-only cycle, ALE never rises, oDone at cycle 6.
- iAddrCount=7: exactly 5 address bytes sent.
- iStart held high throughout, with iCommand changed mid-transaction: the second transaction starts in the DONE cycle and the first transaction's DQ is unaffected.
- Reset asserted during ADDR_WE_LO of byte 3: on the same edge, all outputs return to idle values and oDone never pulses.
- NFC_CMD2_EN with iCmd2Valid=1, command 8'h00, N=5, iCommand2=8'h30: 8'h30 is latched with CLE after the 5th address byte, and oDone comes at cycle 32.

Source files
------------

// File: rtl/nfc_pkg.sv
// Shared types and constants for the NAND command/address sequencer.
package nfc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_SETUP,
        ST_CMD_WE_LO,
        ST_CMD_WE_HI,
        ST_ADDR_SETUP,
        ST_ADDR_WE_LO,
        ST_ADDR_WE_HI,
        ST_CMD2_SETUP,
        ST_CMD2_WE_LO,
        ST_CMD2_WE_HI,
        ST_HOLD,
        ST_DONE
    } nfc_state_t;

    localparam logic [2:0] MAX_ADDR_BYTES = 3'd5;

    localparam logic [3:0] WE_IDLE = 4'hF;
    localparam logic [3:0] RE_IDLE = 4'hF;
    localparam logic       CE_IDLE = 1'b1;

    // Address counts of 6 and 7 saturate to the 5-byte maximum.
    function automatic logic [2:0] clamp_addr_count(input logic [2:0] count);
        return (count > MAX_ADDR_BYTES) ? MAX_ADDR_BYTES : count;
    endfunction

    function automatic logic [7:0] addr_byte(input logic [39:0] addr, input logic [2:0] idx);
        case (idx)
            3'd0:    return addr[7:0];
            3'd1:    return addr[15:8];
            3'd2:    return addr[23:16];
            3'd3:    return addr[31:24];
            default: return addr[39:32];
        endcase
    endfunction

endpackage

// File: rtl/nfc_phase_timer.sv
// Loadable down-counter with terminal-count flag, shared by every timed sequencer state.
module nfc_phase_timer #(
    parameter int Width = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_value,
    output logic             o_terminal
);
    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - One;
        end
    end

    assign o_terminal = (r_count == '0);

endmodule

// File: rtl/nfc_cmd_addr_sequencer.sv
// Sequences one NAND command byte plus 0-5 address bytes with SDR timing on a selected way.
// Define NFC_CMD2_EN to add a second command phase (iCmd2Valid / iCommand2) after the address bytes.
module nfc_cmd_addr_sequencer
    import nfc_pkg::*;
#(
    parameter int NumberOfWays = 4,
    parameter int SetupCycles  = 1,
    parameter int WeLowCycles  = 2,
    parameter int WeHighCycles = 2,
    parameter int HoldCycles   = 1
) (
    input  logic                            iSystemClock,
    input  logic                            iModuleReset,
    input  logic                            iStart,
    input  logic [$clog2(NumberOfWays)-1:0] iTargetWay,
    input  logic [7:0]                      iCommand,
    input  logic [2:0]                      iAddrCount,
    input  logic [39:0]                     iAddress,
`ifdef NFC_CMD2_EN
    input  logic                            iCmd2Valid,
    input  logic [7:0]                      iCommand2,
`endif
    output logic                            oReady,
    output logic                            oDone,
    output logic                            oDQSOutEnable,
    output logic                            oDQOutEnable,
    output logic [7:0]                      oPO_DQStrobe,
    output logic [31:0]                     oPO_DQ,
    output logic [2*NumberOfWays-1:0]       oPO_ChipEnable,
    output logic [3:0]                      oPO_ReadEnable,
    output logic [3:0]                      oPO_WriteEnable,
    output logic [3:0]                      oPO_AddressLatchEnable,
    output logic [3:0]                      oPO_CommandLatchEnable
);
    localparam int WayW      = $clog2(NumberOfWays);
    localparam int MaxSh     = (SetupCycles > HoldCycles) ? SetupCycles : HoldCycles;
    localparam int MaxWe     = (WeLowCycles > WeHighCycles) ? WeLowCycles : WeHighCycles;
    localparam int MaxCycles = (MaxSh > MaxWe) ? MaxSh : MaxWe;
    localparam int CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] LoadSetup = CntW'(SetupCycles - 1);
    localparam logic [CntW-1:0] LoadWeLo  = CntW'(WeLowCycles - 1);
    localparam logic [CntW-1:0] LoadWeHi  = CntW'(WeHighCycles - 1);
    localparam logic [CntW-1:0] LoadHold  = CntW'(HoldCycles - 1);

    nfc_state_t r_state;
    nfc_state_t w_next_state;
    nfc_state_t w_tail_state;

    logic [WayW-1:0] r_way;
    logic [7:0]      r_cmd;
    logic [2:0]      r_addr_cnt;
    logic [39:0]     r_addr;
    logic            r_cmd2_valid;
    logic [7:0]      r_cmd2;
    logic [2:0]      r_addr_idx;
    logic [2:0]      w_next_addr_idx;

    logic            w_cmd2_valid_in;
    logic [7:0]      w_cmd2_in;
    logic            w_accept;
    logic            w_timer_load;
    logic [CntW-1:0] w_timer_value;
    logic            w_timer_tc;
    logic [WayW-1:0] w_way_sel;
    logic [7:0]      w_cmd_sel;

    logic                      r_ready, w_ready;
    logic                      r_done, w_done;
    logic                      r_dq_oe, w_dq_oe;
    logic [7:0]                r_dq, w_dq;
    logic [2*NumberOfWays-1:0] r_ce, w_ce;
    logic [NumberOfWays-1:0]   w_ce_one;
    logic                      w_ce_active;
    logic [3:0]                r_we, w_we;
    logic                      r_ale, w_ale;
    logic                      r_cle, w_cle;

`ifdef NFC_CMD2_EN
    assign w_cmd2_valid_in = iCmd2Valid;
    assign w_cmd2_in       = iCommand2;
`else
    assign w_cmd2_valid_in = 1'b0;
    assign w_cmd2_in       = 8'h00;
`endif

    assign w_accept     = iStart & r_ready;
    assign w_tail_state = r_cmd2_valid ? ST_CMD2_SETUP : ST_HOLD;
    // On the accepting edge the latches are not loaded yet, so the first phase reads the ports.
    assign w_way_sel    = w_accept ? iTargetWay : r_way;
    assign w_cmd_sel    = w_accept ? iCommand : r_cmd;

    nfc_phase_timer #(
        .Width(CntW)
    ) u_phase_timer (
        .i_clk       (iSystemClock),
        .i_rst       (iModuleReset),
        .i_load      (w_timer_load),
        .i_load_value(w_timer_value),
        .o_terminal  (w_timer_tc)
    );

    // NOTE: transaction latches carry no reset; they are only read in busy states, after an acceptance loads them.
    always_ff @(posedge iSystemClock) begin
        if (w_accept) begin
            r_way        <= iTargetWay;
            r_cmd        <= iCommand;
            r_addr_cnt   <= clamp_addr_count(iAddrCount);
            r_addr       <= iAddress;
            r_cmd2_valid <= w_cmd2_valid_in;
            r_cmd2       <= w_cmd2_in;
        end
    end

    always_ff @(posedge iSystemClock or posedge iModuleReset) begin
        if (iModuleReset) begin
            r_state    <= ST_IDLE;
            r_addr_idx <= '0;
        end else begin
            r_state    <= w_next_state;
            r_addr_idx <= w_next_addr_idx;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_addr_idx = r_addr_idx;
        case (r_state)
            ST_IDLE, ST_DONE: w_next_state = w_accept ? ST_CMD_SETUP : ST_IDLE;
            ST_CMD_SETUP:  if (w_timer_tc) w_next_state = ST_CMD_WE_LO;
            ST_CMD_WE_LO:  if (w_timer_tc) w_next_state = ST_CMD_WE_HI;
            ST_CMD_WE_HI:  if (w_timer_tc) w_next_state = (r_addr_cnt != 3'd0) ? ST_ADDR_SETUP : w_tail_state;
            ST_ADDR_SETUP: if (w_timer_tc) w_next_state = ST_ADDR_WE_LO;
            ST_ADDR_WE_LO: if (w_timer_tc) w_next_state = ST_ADDR_WE_HI;
            ST_ADDR_WE_HI: begin
                if (w_timer_tc) begin
                    if (r_addr_idx == r_addr_cnt - 3'd1) begin
                        w_next_state = w_tail_state;
                    end else begin
                        w_next_state    = ST_ADDR_WE_LO;
                        w_next_addr_idx = r_addr_idx + 3'd1;
                    end
                end
            end
            ST_CMD2_SETUP: if (w_timer_tc) w_next_state = ST_CMD2_WE_LO;
            ST_CMD2_WE_LO: if (w_timer_tc) w_next_state = ST_CMD2_WE_HI;
            ST_CMD2_WE_HI: if (w_timer_tc) w_next_state = ST_HOLD;
            ST_HOLD:       if (w_timer_tc) w_next_state = ST_DONE;
            default:       w_next_state = ST_IDLE;
        endcase

        if (w_next_state == ST_ADDR_SETUP) begin
            w_next_addr_idx = '0;
        end

        w_timer_load = (w_next_state != r_state);
        case (w_next_state)
            ST_CMD_SETUP, ST_ADDR_SETUP, ST_CMD2_SETUP: w_timer_value = LoadSetup;
            ST_CMD_WE_LO, ST_ADDR_WE_LO, ST_CMD2_WE_LO: w_timer_value = LoadWeLo;
            ST_CMD_WE_HI, ST_ADDR_WE_HI, ST_CMD2_WE_HI: w_timer_value = LoadWeHi;
            ST_HOLD:                                    w_timer_value = LoadHold;
            default:                                    w_timer_value = '0;
        endcase
    end

    // Outputs are decoded from the state being entered, then registered.
    always_comb begin
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_ce_active = 1'b1;
        w_we        = WE_IDLE;
        w_ale       = r_ale;
        w_cle       = r_cle;
        w_dq        = r_dq;
        w_dq_oe     = r_dq_oe;
        case (w_next_state)
            ST_IDLE, ST_DONE: begin
                w_ready     = 1'b1;
                w_done      = (w_next_state == ST_DONE);
                w_ce_active = 1'b0;
                w_ale       = 1'b0;
                w_cle       = 1'b0;
                w_dq        = 8'h00;
                w_dq_oe     = 1'b0;
            end
            ST_CMD_SETUP, ST_CMD_WE_LO, ST_CMD_WE_HI: begin
                w_cle   = 1'b1;
                w_ale   = 1'b0;
                w_dq    = w_cmd_sel;
                w_dq_oe = 1'b1;
            end
            ST_ADDR_SETUP: begin
                w_cle = 1'b0;
                w_ale = 1'b1;
                w_dq  = addr_byte(r_addr, 3'd0);
            end
            ST_ADDR_WE_LO: begin
                w_ale = 1'b1;
                w_dq  = addr_byte(r_addr, w_next_addr_idx);
            end
            ST_CMD2_SETUP, ST_CMD2_WE_LO, ST_CMD2_WE_HI: begin
                w_cle = 1'b1;
                w_ale = 1'b0;
                w_dq  = r_cmd2;
            end
            default: ;
        endcase

        if (w_next_state inside {ST_CMD_WE_LO, ST_ADDR_WE_LO, ST_CMD2_WE_LO}) begin
            w_we = ~WE_IDLE;
        end

        w_ce_one = {NumberOfWays{CE_IDLE}};
        if (w_ce_active) begin
            w_ce_one[w_way_sel] = ~CE_IDLE;
        end
        w_ce = {w_ce_one, w_ce_one};
    end

    always_ff @(posedge iSystemClock or posedge iModuleReset) begin
        if (iModuleReset) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_dq_oe <= 1'b0;
            r_dq    <= 8'h00;
            r_ce    <= {2*NumberOfWays{CE_IDLE}};
            r_we    <= WE_IDLE;
            r_ale   <= 1'b0;
            r_cle   <= 1'b0;
        end else begin
            r_ready <= w_ready;
            r_done  <= w_done;
            r_dq_oe <= w_dq_oe;
            r_dq    <= w_dq;
            r_ce    <= w_ce;
            r_we    <= w_we;
            r_ale   <= w_ale;
            r_cle   <= w_cle;
        end
    end

    assign oReady                 = r_ready;
    assign oDone                  = r_done;
    assign oDQSOutEnable          = 1'b0;
    assign oDQOutEnable           = r_dq_oe;
    assign oPO_DQStrobe           = 8'h00;
    assign oPO_DQ                 = {8'h00, r_dq, 8'h00, r_dq};
    assign oPO_ChipEnable         = r_ce;
    assign oPO_ReadEnable         = RE_IDLE;
    assign oPO_WriteEnable        = r_we;
    assign oPO_AddressLatchEnable = {4{r_ale}};
    assign oPO_CommandLatchEnable = {4{r_cle}};

endmodule

// File: tb/tb_nfc_cmd_addr_sequencer.sv
// Self-checking bench for nfc_cmd_addr_sequencer: vector table, hand-written corner sequences, random traffic.
// Define NFC_CMD2_EN to exercise the second command phase.
`timescale 1ns/1ps
module tb_nfc_cmd_addr_sequencer;

    localparam int NW    = 4;
    localparam int SETUP = 1;
    localparam int WLO   = 2;
    localparam int WHI   = 2;
    localparam int HOLD  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iStart = 1'b0;
    logic [1:0]  iTargetWay = '0;
    logic [7:0]  iCommand = '0;
    logic [2:0]  iAddrCount = '0;
    logic [39:0] iAddress = '0;
`ifdef NFC_CMD2_EN
    logic        iCmd2Valid = 1'b0;
    logic [7:0]  iCommand2 = '0;
`endif
    logic        oReady, oDone, oDQSOutEnable, oDQOutEnable;
    logic [7:0]  oPO_DQStrobe;
    logic [31:0] oPO_DQ;
    logic [7:0]  oPO_ChipEnable;
    logic [3:0]  oPO_ReadEnable, oPO_WriteEnable, oPO_AddressLatchEnable, oPO_CommandLatchEnable;

    always #5 clk = ~clk;

    nfc_cmd_addr_sequencer dut (
        .iSystemClock          (clk),
        .iModuleReset          (rst),
        .iStart                (iStart),
        .iTargetWay            (iTargetWay),
        .iCommand              (iCommand),
        .iAddrCount            (iAddrCount),
        .iAddress              (iAddress),
`ifdef NFC_CMD2_EN
        .iCmd2Valid            (iCmd2Valid),
        .iCommand2             (iCommand2),
`endif
        .oReady                (oReady),
        .oDone                 (oDone),
        .oDQSOutEnable         (oDQSOutEnable),
        .oDQOutEnable          (oDQOutEnable),
        .oPO_DQStrobe          (oPO_DQStrobe),
        .oPO_DQ                (oPO_DQ),
        .oPO_ChipEnable        (oPO_ChipEnable),
        .oPO_ReadEnable        (oPO_ReadEnable),
        .oPO_WriteEnable       (oPO_WriteEnable),
        .oPO_AddressLatchEnable(oPO_AddressLatchEnable),
        .oPO_CommandLatchEnable(oPO_CommandLatchEnable)
    );

    typedef struct packed {
        logic [7:0]  ce;
        logic [3:0]  we;
        logic [3:0]  re;
        logic [3:0]  ale;
        logic [3:0]  cle;
        logic [31:0] dq;
        logic [7:0]  dqs;
        logic        dqs_oe;
        logic        dq_oe;
        logic        done;
        logic        ready;
    } obs_t;

    typedef struct {
        int          way;
        logic [7:0]  cmd;
        int          n;
        logic [39:0] addr;
        logic        c2v;
        logic [7:0]  c2;
        int          exp_busy;
        int          exp_bytes;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    obs_t       trace[$];
    vec_t       tbl[$];
    int         obs_busy, obs_ce_low, obs_we_min, obs_we_max;
    bit         obs_bad_ce;
    logic [7:0] obs_ale[$];
    logic [7:0] obs_cle[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.ce    = 8'hFF;
        o.we    = 4'hF;
        o.re    = 4'hF;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t busy_obs(input int way, input logic we, input logic ale,
                                      input logic cle, input logic [7:0] dq);
        obs_t o;
        o = idle_obs();
        o.ready      = 1'b0;
        o.ce[way]    = 1'b0;
        o.ce[way+NW] = 1'b0;
        o.we         = {4{we}};
        o.ale        = {4{ale}};
        o.cle        = {4{cle}};
        o.dq         = {8'h00, dq, 8'h00, dq};
        o.dq_oe      = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ce     = oPO_ChipEnable;
        o.we     = oPO_WriteEnable;
        o.re     = oPO_ReadEnable;
        o.ale    = oPO_AddressLatchEnable;
        o.cle    = oPO_CommandLatchEnable;
        o.dq     = oPO_DQ;
        o.dqs    = oPO_DQStrobe;
        o.dqs_oe = oDQSOutEnable;
        o.dq_oe  = oDQOutEnable;
        o.done   = oDone;
        o.ready  = oReady;
        return o;
    endfunction

    task automatic push_n(input obs_t o, input int n);
        repeat (n) trace.push_back(o);
    endtask

    // Reference waveform: one entry per cycle from the accepting edge up to and including DONE.
    task automatic build_trace(input int way, input logic [7:0] cmd, input int n_raw,
                               input logic [39:0] addr, input logic c2v, input logic [7:0] c2);
        int   n;
        obs_t last;
        n = (n_raw > 5) ? 5 : n_raw;
        trace.delete();
        push_n(busy_obs(way, 1'b1, 1'b0, 1'b1, cmd), SETUP);
        push_n(busy_obs(way, 1'b0, 1'b0, 1'b1, cmd), WLO);
        push_n(busy_obs(way, 1'b1, 1'b0, 1'b1, cmd), WHI);
        if (n > 0) begin
            push_n(busy_obs(way, 1'b1, 1'b1, 1'b0, addr[7:0]), SETUP);
            for (int b = 0; b < n; b++) begin
                logic [7:0] byt;
                byt = 8'(addr >> (8 * b));
                push_n(busy_obs(way, 1'b0, 1'b1, 1'b0, byt), WLO);
                push_n(busy_obs(way, 1'b1, 1'b1, 1'b0, byt), WHI);
            end
        end
        if (c2v) begin
            push_n(busy_obs(way, 1'b1, 1'b0, 1'b1, c2), SETUP);
            push_n(busy_obs(way, 1'b0, 1'b0, 1'b1, c2), WLO);
            push_n(busy_obs(way, 1'b1, 1'b0, 1'b1, c2), WHI);
        end
        last = trace[$];
        push_n(last, HOLD);
        last = idle_obs();
        last.done = 1'b1;
        trace.push_back(last);
    endtask

    task automatic start_txn(input int way, input logic [7:0] cmd, input int n,
                             input logic [39:0] addr, input logic c2v, input logic [7:0] c2);
        int k;
        k = 0;
        @(negedge clk);
        while (!oReady && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!oReady) check("ready_wait", oReady, 1);
        iTargetWay = 2'(way);
        iCommand   = cmd;
        iAddrCount = 3'(n);
        iAddress   = addr;
`ifdef NFC_CMD2_EN
        iCmd2Valid = c2v;
        iCommand2  = c2;
`endif
        iStart = 1'b1;
        build_trace(way, cmd, n, addr, c2v, c2);
        @(posedge clk);
    endtask

    // mode 0: drop iStart and scramble inputs after acceptance; mode 1: keep iStart, change iCommand.
    task automatic observe_txn(input int way, input int mode);
        obs_t a, prev;
        int   we_run;
        we_run     = 0;
        prev       = idle_obs();
        obs_busy   = -1;
        obs_ce_low = 0;
        obs_we_min = 1000;
        obs_we_max = 0;
        obs_bad_ce = 1'b0;
        obs_ale.delete();
        obs_cle.delete();
        for (int k = 0; k < trace.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (mode == 1) begin
                    iCommand = 8'h22;
                end else begin
                    iStart     = 1'b0;
                    iTargetWay = 2'($urandom);
                    iCommand   = 8'($urandom);
                    iAddrCount = 3'($urandom);
                    iAddress   = {8'($urandom), 32'($urandom)};
`ifdef NFC_CMD2_EN
                    iCmd2Valid = 1'($urandom);
                    iCommand2  = 8'($urandom);
`endif
                end
            end
            a = sample();
            check($sformatf("trace[%0d]", k), a, trace[k]);
            if (a.done && obs_busy < 0) obs_busy = k;
            if (!a.ce[way] && !a.ce[way+NW]) obs_ce_low++;
            if ($countones(~a.ce[NW-1:0]) > 1 || a.ce[NW-1:0] != a.ce[2*NW-1:NW]) obs_bad_ce = 1'b1;
            if (!a.we[0]) begin
                we_run++;
            end else if (we_run > 0) begin
                if (we_run < obs_we_min) obs_we_min = we_run;
                if (we_run > obs_we_max) obs_we_max = we_run;
                we_run = 0;
            end
            if (!a.we[0] && prev.we[0]) begin
                if (a.ale[0]) obs_ale.push_back(a.dq[7:0]);
                if (a.cle[0]) obs_cle.push_back(a.dq[7:0]);
            end
            prev = a;
        end
        if (mode != 1) begin
            @(negedge clk);
            check("idle_after_done", sample(), idle_obs());
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, not_ready_cnt, way, n, exp_busy;
        logic c2v;
        logic [7:0] cmd, c2;
        logic [39:0] addr;

        tbl.push_back('{2, 8'h00, 5, 40'h0504030201, 1'b0, 8'h00, 27, 5});
        tbl.push_back('{1, 8'hFF, 0, 40'hDEADBEEF12, 1'b0, 8'h00, 6, 0});
        tbl.push_back('{3, 8'h90, 7, 40'hA1B2C3D4E5, 1'b0, 8'h00, 27, 5});
        tbl.push_back('{0, 8'h80, 1, 40'h00000000C7, 1'b0, 8'h00, 11, 1});
        tbl.push_back('{1, 8'h60, 3, 40'h0000332211, 1'b0, 8'h00, 19, 3});
`ifdef NFC_CMD2_EN
        tbl.push_back('{2, 8'h00, 5, 40'h0504030201, 1'b1, 8'h30, 32, 5});
        tbl.push_back('{3, 8'h85, 0, 40'h0000000000, 1'b1, 8'h10, 11, 0});
`endif

        repeat (3) @(negedge clk);
        check("reset_state", sample(), idle_obs());
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", sample(), idle_obs());

        foreach (tbl[i]) begin
            start_txn(tbl[i].way, tbl[i].cmd, tbl[i].n, tbl[i].addr, tbl[i].c2v, tbl[i].c2);
            observe_txn(tbl[i].way, 0);
            check($sformatf("v%0d_busy", i), obs_busy, tbl[i].exp_busy);
            check($sformatf("v%0d_ce_low", i), obs_ce_low, tbl[i].exp_busy);
            check($sformatf("v%0d_one_ce", i), obs_bad_ce, 0);
            check($sformatf("v%0d_we_min", i), obs_we_min, WLO);
            check($sformatf("v%0d_we_max", i), obs_we_max, WLO);
            check($sformatf("v%0d_ale_cnt", i), obs_ale.size(), tbl[i].exp_bytes);
            for (int b = 0; b < obs_ale.size() && b < tbl[i].exp_bytes; b++)
                check($sformatf("v%0d_ale_byte%0d", i, b), obs_ale[b], 8'(tbl[i].addr >> (8 * b)));
            check($sformatf("v%0d_cle_cnt", i), obs_cle.size(), tbl[i].c2v ? 2 : 1);
            if (obs_cle.size() > 0)
                check($sformatf("v%0d_cle_last", i), obs_cle[$], tbl[i].c2v ? tbl[i].c2 : tbl[i].cmd);
        end

        // Back-to-back: iStart held, iCommand changed mid-transaction.
        start_txn(0, 8'h11, 1, 40'h00000000AB, 1'b0, 8'h00);
        observe_txn(0, 1);
        check("b2b_first_busy", obs_busy, 11);
        build_trace(0, 8'h22, 1, 40'h00000000AB, 1'b0, 8'h00);
        @(posedge clk);
        observe_txn(0, 0);
        check("b2b_second_busy", obs_busy, 11);

        // Reset during the first WE-low cycle of address byte 3.
        start_txn(1, 8'h00, 5, 40'h0504030201, 1'b0, 8'h00);
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            iStart = 1'b0;
        end
        check("pre_reset_phase", {oPO_AddressLatchEnable[0], oPO_WriteEnable[0], oPO_DQ[7:0]},
              {1'b1, 1'b0, 8'h04});
        rst = 1'b1;
        #1;
        check("reset_async_idle", sample(), idle_obs());
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        not_ready_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (oDone) done_cnt++;
            if (!oReady) not_ready_cnt++;
        end
        check("reset_no_done", done_cnt, 0);
        check("reset_stays_ready", not_ready_cnt, 0);

        // Random traffic against the reference waveform.
        for (int t = 0; t < 25; t++) begin
            way  = $urandom_range(0, NW - 1);
            cmd  = 8'($urandom);
            n    = $urandom_range(0, 7);
            addr = {8'($urandom), 32'($urandom)};
`ifdef NFC_CMD2_EN
            c2v  = 1'($urandom);
`else
            c2v  = 1'b0;
`endif
            c2   = 8'($urandom);
            exp_busy = SETUP + WLO + WHI + HOLD
                     + ((n > 0) ? SETUP + ((n > 5) ? 5 : n) * (WLO + WHI) : 0)
                     + (c2v ? SETUP + WLO + WHI : 0);
            start_txn(way, cmd, n, addr, c2v, c2);
            observe_txn(way, 0);
            check($sformatf("rnd%0d_busy", t), obs_busy, exp_busy);
            check($sformatf("rnd%0d_one_ce", t), obs_bad_ce, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
